// File: rtl/vera_mem_pkg.sv
// Shared main_ram bus geometry, requester port numbering and the read-return tag type.
package vera_mem_pkg;

  localparam int unsigned MRAM_ADDR_W = 15;
  localparam int unsigned MRAM_DATA_W = 32;
  localparam int unsigned MRAM_NSEL_W = 8;

  localparam int unsigned PORT_IDX_W  = 3;
  localparam int unsigned PORT_HOST   = 0;
  localparam int unsigned PORT_L0     = 1;
  localparam int unsigned PORT_L1     = 2;
  localparam int unsigned PORT_SPR    = 3;

  typedef struct packed {
    logic                  valid;
    logic [PORT_IDX_W-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/main_ram_arbiter_if.sv
// Requester-side bundle of the main_ram arbiter: per-port request fields plus shared read return.
interface main_ram_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4
);
  import vera_mem_pkg::*;

  logic [NUM_PORTS-1:0]             req;
  logic [NUM_PORTS*MRAM_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*MRAM_DATA_W-1:0] req_wrdata;
  logic [NUM_PORTS*MRAM_NSEL_W-1:0] req_wrnibblesel;
  logic [NUM_PORTS-1:0]             req_write;
  logic [NUM_PORTS-1:0]             ack;
  logic [MRAM_DATA_W-1:0]           rd_data;
  logic [NUM_PORTS-1:0]             rd_valid;

  modport master (
    output req, req_addr, req_wrdata, req_wrnibblesel, req_write,
    input  ack, rd_data, rd_valid
  );

  modport slave (
    input  req, req_addr, req_wrdata, req_wrnibblesel, req_write,
    output ack, rd_data, rd_valid
  );

endinterface

// File: rtl/main_ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req_mask at or after pointer, wrapping.
module rr_picker #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_mask,
  input  logic [PW-1:0]    pointer,
  output logic [WIDTH-1:0] grant,
  output logic             found
);

  always_comb begin
    logic [PW:0] sum;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum = {1'b0, pointer} + (PW+1)'(i);
      if (sum >= (PW+1)'(WIDTH)) sum = sum - (PW+1)'(WIDTH);
      if (!found && req_mask[sum[PW-1:0]]) begin
        grant[sum[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/main_ram_arbiter.sv
// Sole master of the main_ram bus: port 0 fixed priority with starvation guard, ports 1..N-1
// round-robin, registered bus outputs, and a tag pipeline steering read data back to its owner.
module main_ram_arbiter
  import vera_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  main_ram_arbiter_if.slave      rq,
  output logic [MRAM_ADDR_W-1:0] bus_addr,
  output logic [MRAM_DATA_W-1:0] bus_wrdata,
  output logic [MRAM_NSEL_W-1:0] bus_wrnibblesel,
  output logic                   bus_write,
  input  logic [MRAM_DATA_W-1:0] bus_rddata
);

  localparam int unsigned PW    = $clog2(NUM_PORTS);
  localparam int unsigned DEPTH = RD_LATENCY + 1;
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  logic [NUM_PORTS-1:0]   ack;
  logic [NUM_PORTS-1:0]   rr_mask;
  logic [NUM_PORTS-1:0]   rr_grant;
  logic                   rr_found;
  logic                   starve_hit;
  logic                   rr_win;
  logic [PW-1:0]          rr_ptr;
  logic [7:0]             starve_cnt;

  logic [MRAM_ADDR_W-1:0] win_addr;
  logic [MRAM_DATA_W-1:0] win_wrdata;
  logic [MRAM_NSEL_W-1:0] win_nsel;
  logic                   win_write;
  logic [PORT_IDX_W-1:0]  win_idx;

  rd_tag_t                tag_pipe [DEPTH];
  logic [MRAM_DATA_W-1:0] rd_data_q;

  assign rr_mask = {rq.req[NUM_PORTS-1:1], 1'b0};

  rr_picker #(
    .WIDTH (NUM_PORTS)
  ) u_rr_picker (
    .req_mask (rr_mask),
    .pointer  (rr_ptr),
    .grant    (rr_grant),
    .found    (rr_found)
  );

  assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX) && rr_found;

  always_comb begin
    ack = '0;
    if (rst_n) begin
      if (rq.req[0] && !starve_hit) ack[0] = 1'b1;
      else if (rr_found)            ack    = rr_grant;
    end
  end

  assign rr_win = (|ack) && !ack[0];
  assign rq.ack = ack;

  always_comb begin
    win_addr   = '0;
    win_wrdata = '0;
    win_nsel   = '0;
    win_write  = 1'b0;
    win_idx    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (ack[p]) begin
        win_addr   = rq.req_addr[p*MRAM_ADDR_W +: MRAM_ADDR_W];
        win_wrdata = rq.req_wrdata[p*MRAM_DATA_W +: MRAM_DATA_W];
        win_nsel   = rq.req_wrnibblesel[p*MRAM_NSEL_W +: MRAM_NSEL_W];
        win_write  = rq.req_write[p];
        win_idx    = PORT_IDX_W'(p);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_addr        <= '0;
      bus_wrdata      <= '0;
      bus_wrnibblesel <= '0;
      bus_write       <= 1'b0;
      rr_ptr          <= PW'(1);
      starve_cnt      <= '0;
      rd_data_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_pipe[i] <= '0;
    end else begin
      bus_write <= 1'b0;
      if (|ack) begin
        bus_addr        <= win_addr;
        bus_wrdata      <= win_wrdata;
        bus_wrnibblesel <= win_nsel;
        bus_write       <= win_write;
      end
      if (rr_win)
        rr_ptr <= (win_idx == PORT_IDX_W'(NUM_PORTS-1)) ? PW'(1) : PW'(win_idx + PORT_IDX_W'(1));
      if (!rr_found || rr_win)
        starve_cnt <= '0;
      else if (ack[0] && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 8'd1;
      tag_pipe[0] <= {(|ack) && !win_write, win_idx};
      for (int unsigned i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (tag_pipe[RD_LATENCY].valid) rd_data_q <= bus_rddata;
    end
  end

  // Returning word is passed straight through in its strobe cycle; the register only holds it afterwards.
  assign rq.rd_data = tag_pipe[RD_LATENCY].valid ? bus_rddata : rd_data_q;

  always_comb begin
    rq.rd_valid = '0;
    if (tag_pipe[RD_LATENCY].valid) rq.rd_valid[PW'(tag_pipe[RD_LATENCY].port)] = 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req_stable
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (rq.req[p] && !ack[p]) |=> (!rq.req[p] ||
        ($stable(rq.req_addr[p*MRAM_ADDR_W +: MRAM_ADDR_W]) &&
         $stable(rq.req_wrdata[p*MRAM_DATA_W +: MRAM_DATA_W]) &&
         $stable(rq.req_wrnibblesel[p*MRAM_NSEL_W +: MRAM_NSEL_W]) &&
         $stable(rq.req_write[p]))));
  end

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Directed bench for main_ram_arbiter: two instances (read latency 1 and 3) with a simple RAM model.
module tb_main_ram_arbiter;
  import vera_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  main_ram_arbiter_if #(.NUM_PORTS(4)) ifa ();
  main_ram_arbiter_if #(.NUM_PORTS(4)) ifb ();

  logic [14:0] bus_addr_a, bus_addr_b;
  logic [31:0] bus_wrdata_a, bus_wrdata_b;
  logic [7:0]  bus_nsel_a, bus_nsel_b;
  logic        bus_write_a, bus_write_b;
  logic [31:0] rddata_a, rddata_b;

  main_ram_arbiter #(.NUM_PORTS(4), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rq(ifa),
    .bus_addr(bus_addr_a), .bus_wrdata(bus_wrdata_a), .bus_wrnibblesel(bus_nsel_a),
    .bus_write(bus_write_a), .bus_rddata(rddata_a)
  );

  main_ram_arbiter #(.NUM_PORTS(4), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rq(ifb),
    .bus_addr(bus_addr_b), .bus_wrdata(bus_wrdata_b), .bus_wrnibblesel(bus_nsel_b),
    .bus_write(bus_write_b), .bus_rddata(rddata_b)
  );

  // RAM model: data for the address seen on the bus appears RD_LATENCY cycles later.
  function automatic logic [31:0] ram_word(input logic [14:0] a);
    if (a == 15'h1000) return 32'h12345678;
    return {a, 2'b01, a};
  endfunction

  logic [14:0] hist_a;
  logic [14:0] hist_b [3];
  always @(posedge clk) begin
    hist_a    <= bus_addr_a;
    hist_b[0] <= bus_addr_b;
    hist_b[1] <= hist_b[0];
    hist_b[2] <= hist_b[1];
  end
  assign rddata_a = ram_word(hist_a);
  assign rddata_b = ram_word(hist_b[2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic post_a(input int unsigned p, input logic [14:0] addr, input logic [31:0] data,
                        input logic [7:0] nsel, input logic wr);
    ifa.req_addr[p*15 +: 15]      = addr;
    ifa.req_wrdata[p*32 +: 32]    = data;
    ifa.req_wrnibblesel[p*8 +: 8] = nsel;
    ifa.req_write[p]              = wr;
    ifa.req[p]                    = 1'b1;
  endtask

  task automatic post_b(input int unsigned p, input logic [14:0] addr, input logic [31:0] data,
                        input logic [7:0] nsel, input logic wr);
    ifb.req_addr[p*15 +: 15]      = addr;
    ifb.req_wrdata[p*32 +: 32]    = data;
    ifb.req_wrnibblesel[p*8 +: 8] = nsel;
    ifb.req_write[p]              = wr;
    ifb.req[p]                    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          exp3 [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1};
    int          cnt  [4];
    logic [3:0]  one;
    logic [3:0]  exp_ack [9] = '{4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0]  exp_rv  [9] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b0, 4'b1000, 4'b0};
    logic [31:0] exp_rd  [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h02028101, 32'h04048202,
                                 32'h04048202, 32'h08088404, 32'h08088404};

    n_run  = 0;
    n_fail = 0;
    one    = 4'b0001;
    rst_n  = 1'b0;
    ifa.req = '0; ifa.req_addr = '0; ifa.req_wrdata = '0; ifa.req_wrnibblesel = '0; ifa.req_write = '0;
    ifb.req = '0; ifb.req_addr = '0; ifb.req_wrdata = '0; ifb.req_wrnibblesel = '0; ifb.req_write = '0;
    tick();
    tick();

    // Reset values, ack suppressed while in reset
    post_a(1, 15'h0010, 32'h0, 8'h0, 1'b0);
    #1;
    check("rst_ack", 32'(ifa.ack), 32'h0);
    check("rst_bus_write", 32'(bus_write_a), 32'h0);
    check("rst_bus_addr", 32'(bus_addr_a), 32'h0);
    check("rst_rd_valid", 32'(ifa.rd_valid), 32'h0);
    check("rst_rd_data", ifa.rd_data, 32'h0);
    ifa.req = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle_ack", 32'(ifa.ack), 32'h0);
      check("idle_bus_write", 32'(bus_write_a), 32'h0);
      check("idle_rd_valid", 32'(ifa.rd_valid), 32'h0);
      tick();
    end

    // Reset in the middle of a read: tag must be flushed
    post_a(1, 15'h0123, 32'h0, 8'h0, 1'b0);
    #1;
    check("flush_ack_p1", 32'(ifa.ack), 32'h2);
    tick();
    ifa.req = '0;
    rst_n   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("flush_rd_valid", 32'(ifa.rd_valid), 32'h0);
      tick();
      if (i == 1) rst_n = 1'b1;
    end

    // Single read from port 2
    post_a(2, 15'h1000, 32'h0, 8'h0, 1'b0);
    #1;
    check("rd_ack_p2", 32'(ifa.ack), 32'h4);
    tick();
    ifa.req = '0;
    #1;
    check("rd_bus_addr", 32'(bus_addr_a), 32'h1000);
    check("rd_bus_write", 32'(bus_write_a), 32'h0);
    check("rd_early_valid", 32'(ifa.rd_valid), 32'h0);
    tick();
    #1;
    check("rd_valid_p2", 32'(ifa.rd_valid), 32'h4);
    check("rd_data", ifa.rd_data, 32'h12345678);
    tick();
    #1;
    check("rd_valid_after", 32'(ifa.rd_valid), 32'h0);
    check("rd_data_hold", ifa.rd_data, 32'h12345678);
    tick();

    // Port 0 priority with starve override every STARVE_LIMIT grants
    do_reset();
    post_a(0, 15'h0001, 32'h0, 8'h0, 1'b0);
    post_a(1, 15'h0002, 32'h0, 8'h0, 1'b0);
    post_a(3, 15'h0003, 32'h0, 8'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("prio_ack_%0d", i), 32'(ifa.ack), 32'(one << exp3[i]));
      tick();
    end
    ifa.req = '0;

    // Round-robin among ports 1..3 with port 0 idle
    do_reset();
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    post_a(1, 15'h0011, 32'h0, 8'h0, 1'b0);
    post_a(2, 15'h0022, 32'h0, 8'h0, 1'b0);
    post_a(3, 15'h0033, 32'h0, 8'h0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (i < 6) check($sformatf("rr_ack_%0d", i), 32'(ifa.ack), 32'(4'b0010 << (i % 3)));
      for (int p = 0; p < 4; p++) if (ifa.ack[p]) cnt[p]++;
      tick();
    end
    ifa.req = '0;
    check("rr_share_p1", 32'(cnt[1]), 32'd34);
    check("rr_share_p2", 32'(cnt[2]), 32'd33);
    check("rr_share_p3", 32'(cnt[3]), 32'd33);
    tick();
    tick();
    tick();

    // Nibble write from port 0
    post_a(0, 15'h4001, 32'hAABBCCDD, 8'h0F, 1'b1);
    #1;
    check("wr_ack_p0", 32'(ifa.ack), 32'h1);
    tick();
    ifa.req = '0;
    #1;
    check("wr_bus_write", 32'(bus_write_a), 32'h1);
    check("wr_bus_addr", 32'(bus_addr_a), 32'h4001);
    check("wr_bus_nsel", 32'(bus_nsel_a), 32'h0F);
    check("wr_bus_data", bus_wrdata_a, 32'hAABBCCDD);
    check("wr_rd_valid0", 32'(ifa.rd_valid), 32'h0);
    tick();
    #1;
    check("wr_bus_write_drop", 32'(bus_write_a), 32'h0);
    check("wr_bus_addr_hold", 32'(bus_addr_a), 32'h4001);
    check("wr_rd_valid1", 32'(ifa.rd_valid), 32'h0);
    tick();
    #1;
    check("wr_rd_valid2", 32'(ifa.rd_valid), 32'h0);
    tick();

    // Back-to-back mixed traffic, read latency 3
    for (int k = 0; k < 9; k++) begin
      ifb.req = '0;
      case (k)
        0: post_b(1, 15'h0101, 32'h0, 8'h00, 1'b0);
        1: post_b(2, 15'h0202, 32'h0, 8'h00, 1'b0);
        2: post_b(0, 15'h0303, 32'h55667788, 8'hFF, 1'b1);
        3: post_b(3, 15'h0404, 32'h0, 8'h00, 1'b0);
        default: ;
      endcase
      #1;
      check($sformatf("mix_ack_%0d", k), 32'(ifb.ack), 32'(exp_ack[k]));
      check($sformatf("mix_rd_valid_%0d", k), 32'(ifb.rd_valid), 32'(exp_rv[k]));
      check($sformatf("mix_bus_write_%0d", k), 32'(bus_write_b), (k == 3) ? 32'h1 : 32'h0);
      if (k >= 4) check($sformatf("mix_rd_data_%0d", k), ifb.rd_data, exp_rd[k]);
      tick();
    end
    ifb.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
